// File: rtl/opcodes_pkg.sv
// opcodes_pkg: shared types for the fetch/decode/execute path.
//   word_t        - 32-bit machine word
//   alu_fn_t      - ALU operation selected by the decoder
//   instruction_t - decoded instruction fields
//   fetch_entry_t - {pc, data} pair as handed over by fetch
// Also provides opcode/funct3 constants and small assembler helpers.
package opcodes_pkg;

    typedef logic [31:0] word_t;

    localparam logic [6:0] opc_lui    = 7'b0110111;
    localparam logic [6:0] opc_auipc  = 7'b0010111;
    localparam logic [6:0] opc_jal    = 7'b1101111;
    localparam logic [6:0] opc_jalr   = 7'b1100111;
    localparam logic [6:0] opc_branch = 7'b1100011;
    localparam logic [6:0] opc_load   = 7'b0000011;
    localparam logic [6:0] opc_store  = 7'b0100011;
    localparam logic [6:0] opc_imm    = 7'b0010011;
    localparam logic [6:0] opc_op     = 7'b0110011;

    localparam logic [2:0] funct3_add_sub = 3'b000;
    localparam logic [2:0] funct3_sll     = 3'b001;
    localparam logic [2:0] funct3_slt     = 3'b010;
    localparam logic [2:0] funct3_sltu    = 3'b011;
    localparam logic [2:0] funct3_xor     = 3'b100;
    localparam logic [2:0] funct3_srl_sra = 3'b101;
    localparam logic [2:0] funct3_or      = 3'b110;
    localparam logic [2:0] funct3_and     = 3'b111;

    typedef enum logic [3:0] {
        alu_add, alu_sub, alu_sll, alu_slt, alu_sltu,
        alu_xor, alu_srl, alu_sra, alu_or,  alu_and
    } alu_fn_t;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        word_t      imm;
        alu_fn_t    alu_fn;
    } instruction_t;

    typedef struct packed {
        word_t pc;
        word_t data;
    } fetch_entry_t;

    function automatic word_t asm_add(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, funct3_add_sub, rd, opc_op};
    endfunction

    function automatic word_t asm_sub(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
        return {7'b0100000, rs2, rs1, funct3_add_sub, rd, opc_op};
    endfunction

endpackage

// File: rtl/decoder.sv
// decoder: purely combinational RV32-style field extraction.
//   data  in  word_t        raw instruction word
//   instr out instruction_t decoded fields, immediate and ALU function
// Unknown opcodes decode to their raw fields with imm=0 and alu_add.
module decoder
    import opcodes_pkg::*;
(
    input  word_t        data,
    output instruction_t instr
);

    always_comb begin
        instr        = '0;
        instr.opcode = data[6:0];
        instr.rd     = data[11:7];
        instr.funct3 = data[14:12];
        instr.rs1    = data[19:15];
        instr.rs2    = data[24:20];
        instr.funct7 = data[31:25];
        instr.alu_fn = alu_add;

        case (data[6:0])
            opc_imm, opc_load, opc_jalr:
                instr.imm = {{20{data[31]}}, data[31:20]};
            opc_store:
                instr.imm = {{20{data[31]}}, data[31:25], data[11:7]};
            opc_branch:
                instr.imm = {{19{data[31]}}, data[31], data[7], data[30:25], data[11:8], 1'b0};
            opc_lui, opc_auipc:
                instr.imm = {data[31:12], 12'b0};
            opc_jal:
                instr.imm = {{11{data[31]}}, data[31], data[19:12], data[20], data[30:21], 1'b0};
            default:
                instr.imm = '0;
        endcase

        // funct7[5] selects sub for register ops only; for shifts it selects
        // arithmetic right shift in both immediate and register forms.
        if (data[6:0] == opc_op || data[6:0] == opc_imm) begin
            case (data[14:12])
                funct3_add_sub: instr.alu_fn = (data[6:0] == opc_op && data[30]) ? alu_sub : alu_add;
                funct3_sll:     instr.alu_fn = alu_sll;
                funct3_slt:     instr.alu_fn = alu_slt;
                funct3_sltu:    instr.alu_fn = alu_sltu;
                funct3_xor:     instr.alu_fn = alu_xor;
                funct3_srl_sra: instr.alu_fn = data[30] ? alu_sra : alu_srl;
                funct3_or:      instr.alu_fn = alu_or;
                default:        instr.alu_fn = alu_and;
            endcase
        end
    end

endmodule

// File: rtl/decode_buffer.sv
// decode_buffer: DEPTH-entry fetch->execute FIFO of {pc, data} with the head
// entry decoded through a decoder instance.
//   clk, reset_n            clock, async active-low reset
//   in_valid/in_ready       fetch handshake; in_ready = (count != DEPTH)
//   in_pc, in_data          fetched word and its address
//   flush                   drops everything buffered, highest priority
//   out_valid/out_ready     execute handshake
//   out_pc, out_instr       presented instruction ('0 when nothing valid)
//   count                   entries in the FIFO (output register excluded)
// Optional: `define DECODE_BUFFER_REG_OUT_EN adds an output register after
// the decoder (push-to-out_valid latency 2, total capacity DEPTH+1).
module decode_buffer
    import opcodes_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  word_t              in_pc,
    input  word_t              in_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output word_t              out_pc,
    output instruction_t       out_instr,
    output logic [PTR_W:0]     count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    fetch_entry_t     head;
    instruction_t     head_instr;
    logic             fifo_valid;
    logic             push;
    logic             pop;

    // State-only ready: a pop while full does not open the input this cycle.
    assign in_ready   = (count != (PTR_W+1)'(DEPTH));
    assign fifo_valid = (count != '0);
    assign push       = in_valid && in_ready && !flush;
    assign head       = mem[rd_ptr];

    decoder u_decoder (
        .data  (head.data),
        .instr (head_instr)
    );

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_pc, in_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef DECODE_BUFFER_REG_OUT_EN
    logic         ro_valid;
    word_t        ro_pc;
    instruction_t ro_instr;
    logic         ro_load;

    // Register refills whenever it is empty or its content is being taken.
    assign ro_load = !ro_valid || out_ready;
    assign pop     = fifo_valid && ro_load && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ro_valid <= 1'b0;
            ro_pc    <= '0;
            ro_instr <= '0;
        end else if (flush) begin
            ro_valid <= 1'b0;
            ro_pc    <= '0;
            ro_instr <= '0;
        end else if (ro_load) begin
            ro_valid <= fifo_valid;
            ro_pc    <= fifo_valid ? head.pc : '0;
            ro_instr <= fifo_valid ? head_instr : '0;
        end
    end

    assign out_valid = ro_valid;
    assign out_pc    = ro_pc;
    assign out_instr = ro_instr;
`else
    assign pop       = fifo_valid && out_ready && !flush;
    assign out_valid = fifo_valid;
    assign out_pc    = fifo_valid ? head.pc : '0;
    assign out_instr = fifo_valid ? head_instr : '0;
`endif

endmodule

// File: tb/tb_decode_buffer.sv
// tb_decode_buffer: directed, table-driven bench for decode_buffer (DEPTH=4,
// combinational-head build). Each vector drives one cycle of inputs and
// lists the outputs expected just after that clock edge.
module tb_decode_buffer;
    import opcodes_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic           clk = 1'b0;
    logic           reset_n;
    logic           in_valid;
    logic           in_ready;
    word_t          in_pc;
    word_t          in_data;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    word_t          out_pc;
    instruction_t   out_instr;
    logic [PTR_W:0] count;

    always #5 clk = ~clk;

    decode_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic       iv;
        word_t      pc;
        word_t      data;
        logic       fl;
        logic       ordy;
        logic       e_ov;
        word_t      e_pc;
        logic [4:0] e_rd;
        alu_fn_t    e_alu;
        logic [2:0] e_cnt;
        logic       e_ir;
    } vec_t;

    vec_t vecs[$];

    // Test program: rd = pc[6:2]+1, rs1 = rd+1, rs2 = rd+2; sub when pc[3:2]==2.
    function automatic logic [4:0] rd_of(input word_t pc);
        return pc[6:2] + 5'd1;
    endfunction

    function automatic word_t enc(input word_t pc);
        logic [4:0] rd;
        rd = rd_of(pc);
        return (pc[3:2] == 2'b10) ? asm_sub(rd, rd + 5'd1, rd + 5'd2)
                                  : asm_add(rd, rd + 5'd1, rd + 5'd2);
    endfunction

    task automatic add(input logic iv, input word_t pc, input logic fl, input logic ordy,
                       input logic e_ov, input word_t e_pc, input logic [2:0] e_cnt,
                       input logic e_ir);
        vec_t v;
        v.iv    = iv;
        v.pc    = pc;
        v.data  = enc(pc);
        v.fl    = fl;
        v.ordy  = ordy;
        v.e_ov  = e_ov;
        v.e_pc  = e_pc;
        v.e_rd  = e_ov ? rd_of(e_pc) : 5'd0;
        v.e_alu = (e_ov && e_pc[3:2] == 2'b10) ? alu_sub : alu_add;
        v.e_cnt = e_cnt;
        v.e_ir  = e_ir;
        vecs.push_back(v);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // ---- reset state (edge at t=5 falls inside reset) ----
        #12;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst count",     64'(count),     64'd0);
        chk("rst in_ready",  64'(in_ready),  64'd1);
        chk("rst out_pc",    64'(out_pc),    64'd0);
        chk("rst instr_zero", 64'(out_instr != '0), 64'd0);
        reset_n = 1'b1;

        // ---- single push, fill to full, reject when full, drain in order ----
        add(1, 32'h100, 0, 0, 1, 32'h100, 1, 1);
        add(1, 32'h104, 0, 0, 1, 32'h100, 2, 1);
        add(1, 32'h108, 0, 0, 1, 32'h100, 3, 1);
        add(1, 32'h10C, 0, 0, 1, 32'h100, 4, 0);
        add(1, 32'h110, 0, 0, 1, 32'h100, 4, 0);   // full: not accepted
        add(1, 32'h110, 0, 1, 1, 32'h104, 3, 1);   // full + pop: push still blocked
        add(0, 32'h0,   0, 1, 1, 32'h108, 2, 1);
        add(0, 32'h0,   0, 1, 1, 32'h10C, 1, 1);
        add(0, 32'h0,   0, 1, 0, 32'h0,   0, 1);
        add(0, 32'h0,   0, 1, 0, 32'h0,   0, 1);   // pop on empty: no underflow
        // ---- streaming: one in, one out per cycle, pointers wrap ----
        add(1, 32'h200, 0, 1, 1, 32'h200, 1, 1);
        for (int k = 1; k <= 10; k++)
            add(1, 32'h200 + 32'(4 * k), 0, 1, 1, 32'h200 + 32'(4 * k), 1, 1);
        add(0, 32'h0,   0, 1, 0, 32'h0,   0, 1);
        // ---- flush with concurrent push and pop ----
        add(1, 32'h300, 0, 0, 1, 32'h300, 1, 1);
        add(1, 32'h304, 0, 0, 1, 32'h300, 2, 1);
        add(1, 32'h308, 0, 0, 1, 32'h300, 3, 1);
        add(1, 32'h30C, 1, 1, 0, 32'h0,   0, 1);
        add(0, 32'h0,   0, 0, 0, 32'h0,   0, 1);   // flushed push was not stored
        add(1, 32'h310, 0, 0, 1, 32'h310, 1, 1);
        add(0, 32'h0,   0, 1, 0, 32'h0,   0, 1);
        // ---- consumer stall: outputs hold for 5 cycles ----
        add(1, 32'h400, 0, 0, 1, 32'h400, 1, 1);
        for (int k = 0; k < 5; k++)
            add(0, 32'h0, 0, 0, 1, 32'h400, 1, 1);
        add(0, 32'h0,   0, 1, 0, 32'h0,   0, 1);

        foreach (vecs[i]) begin
            in_valid  = vecs[i].iv;
            in_pc     = vecs[i].pc;
            in_data   = vecs[i].data;
            flush     = vecs[i].fl;
            out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            chk($sformatf("v%0d out_pc", i),    64'(out_pc),    64'(vecs[i].e_pc));
            chk($sformatf("v%0d rd", i),        64'(out_instr.rd), 64'(vecs[i].e_rd));
            chk($sformatf("v%0d alu_fn", i),    64'(out_instr.alu_fn), 64'(vecs[i].e_alu));
            chk($sformatf("v%0d count", i),     64'(count),     64'(vecs[i].e_cnt));
            chk($sformatf("v%0d in_ready", i),  64'(in_ready),  64'(vecs[i].e_ir));
            if (!vecs[i].e_ov)
                chk($sformatf("v%0d instr_zero", i), 64'(out_instr != '0), 64'd0);
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // ---- asynchronous reset between edges with two entries held ----
        in_valid = 1'b1;
        in_pc    = 32'h500;
        in_data  = enc(32'h500);
        @(posedge clk); #1;
        in_pc    = 32'h504;
        in_data  = enc(32'h504);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre-reset count", 64'(count), 64'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async rst count",     64'(count),     64'd0);
        chk("async rst out_valid", 64'(out_valid), 64'd0);
        chk("async rst out_pc",    64'(out_pc),    64'd0);
        chk("async rst in_ready",  64'(in_ready),  64'd1);
        #2;
        reset_n = 1'b1;

        // ---- first push after reset: full field check ----
        in_valid = 1'b1;
        in_pc    = 32'h100;
        in_data  = asm_add(5'd1, 5'd2, 5'd3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("post-rst out_valid", 64'(out_valid),        64'd1);
        chk("post-rst out_pc",    64'(out_pc),           64'h100);
        chk("post-rst opcode",    64'(out_instr.opcode), 64'(opc_op));
        chk("post-rst rd",        64'(out_instr.rd),     64'd1);
        chk("post-rst rs1",       64'(out_instr.rs1),    64'd2);
        chk("post-rst rs2",       64'(out_instr.rs2),    64'd3);
        chk("post-rst funct3",    64'(out_instr.funct3), 64'(funct3_add_sub));
        chk("post-rst alu_fn",    64'(out_instr.alu_fn), 64'(alu_add));
        chk("post-rst count",     64'(count),            64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("final out_valid", 64'(out_valid), 64'd0);
        chk("final count",     64'(count),     64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode_buffer.md
Name: decode_buffer

Overview:
- Parametrised successor to the combinational `decoder`.
- Sits between fetch and execute: a DEPTH-entry FIFO of fetched {pc, data} pairs with valid/ready on both sides.
- The head entry is decoded through an internal `decoder` instance and presented as `instruction_t`.
- Supports pipeline flush (branch/jump/trap redirect) and an optional registered output stage.

Parameters:
- DEPTH, 4: FIFO entries. Must be a power of two, >= 2.
- PTR_W, $clog2(DEPTH): read/write pointer width (derived; do not override).

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents a word
- in_ready  out  1  buffer can accept: count < DEPTH
- in_pc  in  32  address of the fetched word (word_t)
- in_data  in  32  fetched instruction word (word_t)
- flush  in  1  discard all buffered and in-flight entries
- out_valid  out  1  decoded instruction available
- out_ready  in  1  consumer takes the instruction
- out_pc  out  32  pc of the presented instruction
- out_instr  out  instruction_t  decoded fields of the presented instruction
- count  out  PTR_W+1  number of entries held, excluding the output register

Behaviour:
- Reset (async, reset_n=0):
  - rd_ptr=0, wr_ptr=0, count=0, out_valid=0.
  - out_pc='0, out_instr='0.
  - Storage contents are not reset.
- Push: in_valid && in_ready && !flush writes {in_pc, in_data} at wr_ptr; wr_ptr increments.
- Pop: out_valid && out_ready && !flush advances rd_ptr.
- Pointers wrap modulo DEPTH by natural PTR_W overflow.
- in_ready = (count != DEPTH).
  - Purely a function of state; no combinational path from out_ready.
  - When full, a simultaneous pop does not open in_ready that cycle.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Count update: count +1 on push-only, -1 on pop-only; never exceeds DEPTH, never goes below 0.
- Empty: out_valid=0, and out_pc/out_instr are forced to '0.
- Latency without the optional feature:
  - A word accepted at edge N gives out_valid=1 after edge N, with out_instr = decoder(head data) combinationally.
- No bypass: an empty buffer never forwards in_data combinationally to the outputs.
- Consumer stall: while out_valid && !out_ready, out_pc/out_instr stay stable.
- Flush, when sampled high at an edge:
  - rd_ptr=0, wr_ptr=0, count=0, out_valid=0.
  - Concurrent push and pop are both ignored.
  - in_ready=1 in the following cycle.
- Flush has priority over every other event.
- Reset asserted mid-operation: state cleared immediately (asynchronous), regardless of clk.
- No illegal-instruction detection here; decoder output passes through unmodified.

Optional Feature:
- Macro: DECODE_BUFFER_REG_OUT_EN.
- Defined:
  - Adds an output register {out_valid, out_pc, out_instr} loaded from the decoded FIFO head whenever the register is empty or being popped.
  - Breaks the storage->decoder->execute combinational path.
  - Push-to-out_valid latency becomes 2 edges.
  - Flush clears the register as well as the FIFO.
  - The register resets to out_valid=0, out_pc='0, out_instr='0.
  - Capacity is DEPTH+1 in total; count excludes the output register; in_ready still depends on count only.
- Undefined: combinational head decode as described in Behaviour, with latency 1.

Decomposition:
- opcodes_pkg gains `fetch_entry_t` (packed struct {word_t pc; word_t data;}) so fetch and tests share it.
- word_t and instruction_t stay in opcodes_pkg.
- One sub-module: the existing `decoder` (ports data, instr), instantiated once on the head entry's data.
- The FIFO is inline; no separate fifo module.

Test Plan:
1. After reset, push pc=0x0000_0100, data=asm_add(1,2,3) with out_ready=0 -> next cycle out_valid=1, out_pc=0x100, out_instr.rd=1, rs1=2, rs2=3, funct3=funct3_add_sub, alu_fn=alu_add, count=1. With REG_OUT_EN, out_valid rises one cycle later.
2. Push DEPTH=4 words with out_ready=0 -> count=4, in_ready=0. A fifth in_valid is not accepted. Then out_ready=1 -> pcs emerge in order 0x100, 0x104, 0x108, 0x10C, and in_ready=1 after the first pop.
3. Steady streaming, in_valid=out_ready=1 for 10 cycles with pc incrementing by 4 -> count constant at 1, one instruction per cycle, pointers wrap past 3 without loss or duplication.
4. Buffer holding 3 entries, assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0, out_pc=0, out_instr='0. The pushed word is not stored and no pop is recorded.
5. Deassert reset_n between clock edges while count=2 -> count=0 and out_valid=0 immediately, before the next edge. After release, the first push behaves as in scenario 1.
6. Hold out_ready=0 for 5 cycles with out_valid=1 -> out_pc/out_instr unchanged every cycle, count unchanged absent pushes.
